cbuf_trig_scheduler: RTL and testbench

Front-end trigger scheduler for the circular-buffer-to-DDR3 readout path.
- Accepts raw trigger pulses and applies enable and hold-off.
- Computes the circular-buffer start address (write pointer minus pre-trigger length) and pushes it into the trigger address FIFO that the readout state machine drains.
- Tracks outstanding waveforms until the readout side reports completion; keeps accepted/dropped statistics.

---
 rtl/cbuf_trig_pkg.sv | 25 ++
 rtl/cbuf_sat_cntr.sv | 36 +++
 rtl/cbuf_trig_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_cbuf_trig_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cbuf_trig_pkg.sv
// Shared definitions for the circular-buffer trigger scheduler.
// Optional feature macro: CBUF_TRIG_TIMESTAMP_EN (widens the FIFO word with a
// 32-bit timestamp of the trigger cycle).
package cbuf_trig_pkg;

    // Default geometry of the readout path
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_CNT_W  = 24;
    localparam int TS_W       = 32;

    // Scheduler states (plain constants for compatibility with older tools)
    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_HOLDOFF  = 2'd2;

    // Width of one trigger FIFO word; shared with the FIFO instantiation
    function automatic int din_w(input int addr_w);
`ifdef CBUF_TRIG_TIMESTAMP_EN
        return addr_w + TS_W;
`else
        return addr_w;
`endif
    endfunction

endpackage

// File: rtl/cbuf_sat_cntr.sv
// Saturating up-counter with synchronous clear; the value never wraps.
module cbuf_sat_cntr #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next value: clear wins, otherwise count up until all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register (clear is folded into cnt_d)
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cbuf_trig_scheduler.sv
// Trigger scheduler front end for the circular-buffer-to-DDR3 readout path.
// Applies enable and hold-off to raw triggers, pushes the circular-buffer start
// address into the trigger FIFO, tracks outstanding waveforms and keeps
// accepted/dropped statistics. All outputs are registered.
// Optional feature macro: CBUF_TRIG_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter whose value at the trigger cycle is prepended to the FIFO word.
module cbuf_trig_scheduler
    import cbuf_trig_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_PEND = 4
) (
    input  logic                      adc_clk,
    input  logic                      reset_clk_adc,
    input  logic                      trig_in,
    input  logic                      trig_en,
    input  logic [ADDR_W-1:0]         cbuf_wr_addr,
    input  logic [ADDR_W-1:0]         pretrig_len,
    input  logic [15:0]               holdoff_len,
    input  logic                      trig_fifo_full,
    input  logic                      cbuf_to_ddr3_done,
    output logic                      trig_fifo_wr_en,
    output logic [din_w(ADDR_W)-1:0]  trig_fifo_din,
    output logic [3:0]                pend_cnt,
    output logic                      busy,
    output logic [CNT_W-1:0]          trig_acc_cnt,
    output logic [CNT_W-1:0]          trig_drop_cnt,
    output logic                      err_underflow
);

    localparam int         DIN_W      = din_w(ADDR_W);
    localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);

    logic [1:0]       state_d,    state_q;
    logic [15:0]      hold_cnt_d, hold_cnt_q;
    logic             wr_en_d,    wr_en_q;
    logic [DIN_W-1:0] din_d,      din_q;
    logic [3:0]       pend_d,     pend_q;
    logic             busy_d,     busy_q;
    logic             err_d,      err_q;

    logic              accept_s;
    logic              drop_s;
    logic [ADDR_W-1:0] start_addr_s;

    // Start address wraps naturally modulo 2^ADDR_W
    assign start_addr_s = cbuf_wr_addr - pretrig_len;

`ifdef CBUF_TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_d, ts_q;

    // Free-running cycle counter, wraps at 2^32
    always_comb begin
        ts_d = ts_q + 32'd1;
    end

    // Timestamp register
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`endif

    // Trigger FSM: enable, acceptance, drop and hold-off handling
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                if (trig_en) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_DISABLED;
                end
            end
            ST_ARMED: begin
                if (!trig_en) begin
                    // A trigger coinciding with the disable is ignored
                    state_d = ST_DISABLED;
                end else if (trig_in) begin
                    if (!trig_fifo_full && (pend_q < MAX_PEND_C)) begin
                        accept_s   = 1'b1;
                        hold_cnt_d = holdoff_len;
                        state_d    = ST_HOLDOFF;
                    end else begin
                        drop_s  = 1'b1;
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_HOLDOFF: begin
                drop_s = trig_in;
                if (hold_cnt_q == 16'd0) begin
                    if (trig_en) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_DISABLED;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d    = ST_DISABLED;
                hold_cnt_d = 16'd0;
            end
        endcase
    end

    // FIFO push strobe and data, captured from the trigger cycle
    always_comb begin
        wr_en_d = accept_s;
        din_d   = din_q;
        if (accept_s) begin
`ifdef CBUF_TRIG_TIMESTAMP_EN
            din_d = {ts_q, start_addr_s};
`else
            din_d = start_addr_s;
`endif
        end else begin
            din_d = din_q;
        end
    end

    // Outstanding-waveform accounting and underflow detection
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (accept_s && cbuf_to_ddr3_done) begin
            pend_d = pend_q;
        end else if (accept_s) begin
            pend_d = pend_q + 4'd1;
        end else if (cbuf_to_ddr3_done) begin
            if (pend_q == 4'd0) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - 4'd1;
            end
        end else begin
            pend_d = pend_q;
        end
        busy_d = (pend_d != 4'd0);
    end

    // State and output registers
    always_ff @(posedge adc_clk) begin
        if (reset_clk_adc) begin
            state_q    <= ST_DISABLED;
            hold_cnt_q <= 16'd0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
            pend_q     <= 4'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    cbuf_sat_cntr #(.W(CNT_W)) u_acc_cntr (
        .clk (adc_clk),
        .clr (reset_clk_adc),
        .inc (accept_s),
        .cnt (trig_acc_cnt)
    );

    cbuf_sat_cntr #(.W(CNT_W)) u_drop_cntr (
        .clk (adc_clk),
        .clr (reset_clk_adc),
        .inc (drop_s),
        .cnt (trig_drop_cnt)
    );

    assign trig_fifo_wr_en = wr_en_q;
    assign trig_fifo_din   = din_q;
    assign pend_cnt        = pend_q;
    assign busy            = busy_q;
    assign err_underflow   = err_q;

endmodule

// File: tb/tb_cbuf_trig_scheduler.sv
// Directed self-checking bench for cbuf_trig_scheduler. Counters are built
// 3 bits wide so that saturation at 7 is reached during the run.
module tb_cbuf_trig_scheduler;
    import cbuf_trig_pkg::*;

    localparam int AW = 14;
    localparam int CW = 3;
    localparam int MP = 4;
    localparam int DW = din_w(AW);

    logic          clk = 1'b0;
    logic          rst;
    logic          trig_in;
    logic          trig_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] pretrig;
    logic [15:0]   holdoff;
    logic          fifo_full;
    logic          done;
    logic          wr_en;
    logic [DW-1:0] din;
    logic [3:0]    pend;
    logic          busy;
    logic [CW-1:0] acc;
    logic [CW-1:0] drop;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;
    int acc_e  = 0;
    int drop_e = 0;

    cbuf_trig_scheduler #(.ADDR_W(AW), .CNT_W(CW), .MAX_PEND(MP)) dut (
        .adc_clk           (clk),
        .reset_clk_adc     (rst),
        .trig_in           (trig_in),
        .trig_en           (trig_en),
        .cbuf_wr_addr      (wr_addr),
        .pretrig_len       (pretrig),
        .holdoff_len       (holdoff),
        .trig_fifo_full    (fifo_full),
        .cbuf_to_ddr3_done (done),
        .trig_fifo_wr_en   (wr_en),
        .trig_fifo_din     (din),
        .pend_cnt          (pend),
        .busy              (busy),
        .trig_acc_cnt      (acc),
        .trig_drop_cnt     (drop),
        .err_underflow     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    initial begin
        rst = 1'b1; trig_in = 1'b0; trig_en = 1'b0; wr_addr = 14'h0100;
        pretrig = 14'h0040; holdoff = 16'd0; fifo_full = 1'b0; done = 1'b0;
        step(); step();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_din",   32'(din[AW-1:0]), 32'd0);
        check("rst_pend",  32'(pend), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_acc",   32'(acc), 32'd0);
        check("rst_drop",  32'(drop), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b0;

        // Basic accept: 0x0100 - 0x0040 = 0x00C0
        trig_en = 1'b1;
        step();
        trig_in = 1'b1;
        step();
        acc_e++;
        check("basic_wr_en", 32'(wr_en), 32'd1);
        check("basic_din",   32'(din[AW-1:0]), 32'h00C0);
        check("basic_acc",   32'(acc), 32'(sat(acc_e)));
        check("basic_pend",  32'(pend), 32'd1);
        check("basic_busy",  32'(busy), 32'd1);
        trig_in = 1'b0;
        step();
        check("basic_pulse_end", 32'(wr_en), 32'd0);

        // Wrap: 0x0005 - 0x0010 = 0x3FF5
        wr_addr = 14'h0005; pretrig = 14'h0010; trig_in = 1'b1;
        step();
        acc_e++;
        check("wrap_wr_en", 32'(wr_en), 32'd1);
        check("wrap_din",   32'(din[AW-1:0]), 32'h3FF5);
        check("wrap_pend",  32'(pend), 32'd2);
        trig_in = 1'b0;
        step();

        // Accept and done in the same cycle leave pend unchanged
        trig_in = 1'b1; done = 1'b1;
        step();
        acc_e++;
        check("accdone_wr_en", 32'(wr_en), 32'd1);
        check("accdone_pend",  32'(pend), 32'd2);
        check("accdone_acc",   32'(acc), 32'(sat(acc_e)));
        trig_in = 1'b0;
        step();
        step();
        check("drain_pend", 32'(pend), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_err",  32'(err), 32'd0);
        step();
        check("underflow_err",  32'(err), 32'd1);
        check("underflow_pend", 32'(pend), 32'd0);
        done = 1'b0;
        step();
        check("underflow_sticky", 32'(err), 32'd1);

        // Hold-off of 10: triggers at 0, 5, 12 -> accept, drop, accept
        holdoff = 16'd10;
        for (int c = 0; c <= 12; c++) begin
            trig_in = (c == 0 || c == 5 || c == 12);
            step();
            if (c == 0) begin
                acc_e++;
                check("hold_t0_wr_en", 32'(wr_en), 32'd1);
                check("hold_t0_acc",   32'(acc), 32'(sat(acc_e)));
            end else if (c == 5) begin
                drop_e++;
                check("hold_t5_wr_en", 32'(wr_en), 32'd0);
                check("hold_t5_drop",  32'(drop), 32'(drop_e));
            end else if (c == 12) begin
                acc_e++;
                check("hold_t12_wr_en", 32'(wr_en), 32'd1);
                check("hold_t12_acc",   32'(acc), 32'(sat(acc_e)));
                check("hold_t12_pend",  32'(pend), 32'd2);
            end
        end
        trig_in = 1'b0;
        holdoff = 16'd0;
        repeat (11) step();
        done = 1'b1;
        step(); step();
        done = 1'b0;
        check("hold_drain_pend", 32'(pend), 32'd0);

        // MAX_PEND: five triggers without completions -> four pushes, one drop
        for (int k = 0; k < 5; k++) begin
            trig_in = 1'b1;
            step();
            if (k < 4) acc_e++;
            else drop_e++;
            check($sformatf("maxp_wr_en_%0d", k), 32'(wr_en), (k < 4) ? 32'd1 : 32'd0);
            trig_in = 1'b0;
            repeat (19) step();
        end
        check("maxp_pend", 32'(pend), 32'd4);
        check("maxp_acc_sat", 32'(acc), 32'(sat(acc_e)));
        check("maxp_drop", 32'(drop), 32'(drop_e));
        done = 1'b1;
        step();
        done = 1'b0;
        check("maxp_done_pend", 32'(pend), 32'd3);
        trig_in = 1'b1;
        step();
        acc_e++;
        check("maxp_refill_wr_en", 32'(wr_en), 32'd1);
        check("maxp_refill_pend",  32'(pend), 32'd4);
        check("maxp_refill_acc",   32'(acc), 32'(sat(acc_e)));
        trig_in = 1'b0;
        step();
        done = 1'b1;
        repeat (4) step();
        done = 1'b0;
        check("maxp_drain_pend", 32'(pend), 32'd0);

        // FIFO full at the trigger cycle -> drop, no push
        fifo_full = 1'b1; trig_in = 1'b1;
        step();
        drop_e++;
        check("full_wr_en", 32'(wr_en), 32'd0);
        check("full_drop",  32'(drop), 32'(drop_e));
        fifo_full = 1'b0; trig_in = 1'b0;
        step();

        // Disabled: triggers neither pushed nor counted
        trig_en = 1'b0; trig_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("dis_wr_en_%0d", k), 32'(wr_en), 32'd0);
        end
        trig_in = 1'b0;
        check("dis_acc",  32'(acc), 32'(sat(acc_e)));
        check("dis_drop", 32'(drop), 32'(drop_e));
        check("dis_pend", 32'(pend), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
